// File: rtl/tt_um_emern_scan_ctrl.sv
// Raster scan controller for the badGPU display path.
// Generates VGA h/v timing, maps pixels onto the polygon grid, opens the
// SPI load window and issues the once-per-frame commit strobe. Every output
// is registered from a decode of the *next* position, so all outputs in a
// cycle describe the position shown on h_count_out/v_count_out.
module tt_um_emern_scan_ctrl #(
    parameter int H_VIS       = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_VIS       = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int X_DIV       = 5,
    parameter int Y_DIV       = 7,
    parameter int GRID_W      = 128,
    parameter int GRID_H      = 64,
    parameter int LOAD_GUARD  = 4,
    parameter int VBLANK_LOAD = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_screen_in,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic [9:0] h_count_out,
    output logic [9:0] v_count_out,
    output logic       visible_out,
    output logic [6:0] grid_x_out,
    output logic [5:0] grid_y_out,
    output logic       grid_valid_out,
    output logic       en_load_out,
    output logic       line_start_out,
    output logic       frame_commit_out
);

    localparam logic [9:0] H_LAST    = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] H_FRONT   = 10'(H_VIS);
    localparam logic [9:0] H_SYNC_AT = 10'(H_VIS + H_FP);
    localparam logic [9:0] H_BACK_AT = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] V_LAST    = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] V_FRONT   = 10'(V_VIS);
    localparam logic [9:0] V_SYNC_AT = 10'(V_VIS + V_FP);
    localparam logic [9:0] V_BACK_AT = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic [9:0] GX_LIM    = 10'(GRID_W * X_DIV);
    localparam logic [9:0] GY_LIM    = 10'(GRID_H * Y_DIV);
    localparam logic [9:0] LOAD_LO   = 10'(H_VIS + LOAD_GUARD);
    localparam logic [9:0] LOAD_HI   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1 - LOAD_GUARD);
    localparam logic [7:0] X_LAST    = 8'(X_DIV - 1);
    localparam logic [7:0] Y_LAST    = 8'(Y_DIV - 1);
    localparam logic       VBL_EN    = (VBLANK_LOAD != 0);

    typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} region_t;

    region_t    h_state, h_state_nxt, v_state, v_state_nxt;
    logic [9:0] h_nxt, v_nxt;
    logic [9:0] gx_cnt, gy_cnt, gx_nxt, gy_nxt;
    logic [7:0] x_sub, y_sub, x_sub_nxt, y_sub_nxt;
    logic       h_wrap, frame_wrap;
    logic       screen_en, screen_en_nxt, started;
    logic       vis_nxt, gv_nxt, el_nxt;

    // Next-position, region FSMs, grid sub-counters and output decode
    always_comb begin
        h_state_nxt   = h_state;
        v_state_nxt   = v_state;
        x_sub_nxt     = x_sub;
        y_sub_nxt     = y_sub;
        gx_nxt        = gx_cnt;
        gy_nxt        = gy_cnt;

        h_wrap        = (h_count_out == H_LAST);
        frame_wrap    = h_wrap && (v_count_out == V_LAST);
        h_nxt         = h_wrap ? '0 : h_count_out + 10'd1;
        v_nxt         = v_count_out;
        if (h_wrap)
            v_nxt = (v_count_out == V_LAST) ? '0 : v_count_out + 10'd1;

        // The enable is only re-sampled on a real frame boundary, never on
        // the reset-exit step into (0,0), so the first frame stays dark.
        screen_en_nxt = (frame_wrap && started) ? en_screen_in : screen_en;

        unique case (h_state)
            ACTIVE: if (h_nxt == H_FRONT)   h_state_nxt = FRONT;
            FRONT:  if (h_nxt == H_SYNC_AT) h_state_nxt = SYNC;
            SYNC:   if (h_nxt == H_BACK_AT) h_state_nxt = BACK;
            BACK:   if (h_nxt == '0)        h_state_nxt = ACTIVE;
            default:                        h_state_nxt = ACTIVE;
        endcase

        if (h_wrap) begin
            unique case (v_state)
                ACTIVE: if (v_nxt == V_FRONT)   v_state_nxt = FRONT;
                FRONT:  if (v_nxt == V_SYNC_AT) v_state_nxt = SYNC;
                SYNC:   if (v_nxt == V_BACK_AT) v_state_nxt = BACK;
                BACK:   if (v_nxt == '0)        v_state_nxt = ACTIVE;
                default:                        v_state_nxt = ACTIVE;
            endcase
        end

        if (h_nxt == '0) begin
            x_sub_nxt = '0;
            gx_nxt    = '0;
        end else if (x_sub == X_LAST) begin
            x_sub_nxt = '0;
            gx_nxt    = gx_cnt + 10'd1;
        end else begin
            x_sub_nxt = x_sub + 8'd1;
        end

        if (h_wrap) begin
            if (v_nxt == '0) begin
                y_sub_nxt = '0;
                gy_nxt    = '0;
            end else if (y_sub == Y_LAST) begin
                y_sub_nxt = '0;
                gy_nxt    = gy_cnt + 10'd1;
            end else begin
                y_sub_nxt = y_sub + 8'd1;
            end
        end

        vis_nxt = screen_en_nxt && (h_state_nxt == ACTIVE) && (v_state_nxt == ACTIVE);
        gv_nxt  = vis_nxt && (h_nxt < GX_LIM) && (v_nxt < GY_LIM);
        el_nxt  = !screen_en_nxt
                  || ((h_nxt >= LOAD_LO) && (h_nxt <= LOAD_HI))
                  || (VBL_EN && (v_nxt >= V_FRONT));
    end

    // State, counters and registered outputs; reset parks at the last position
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_state          <= BACK;
            v_state          <= BACK;
            h_count_out      <= H_LAST;
            v_count_out      <= V_LAST;
            x_sub            <= '0;
            y_sub            <= '0;
            gx_cnt           <= '0;
            gy_cnt           <= '0;
            screen_en        <= 1'b0;
            started          <= 1'b0;
            hsync_out        <= 1'b1;
            vsync_out        <= 1'b1;
            visible_out      <= 1'b0;
            grid_valid_out   <= 1'b0;
            grid_x_out       <= '0;
            grid_y_out       <= '0;
            en_load_out      <= VBL_EN;
            line_start_out   <= 1'b0;
            frame_commit_out <= 1'b0;
        end else begin
            h_state          <= h_state_nxt;
            v_state          <= v_state_nxt;
            h_count_out      <= h_nxt;
            v_count_out      <= v_nxt;
            x_sub            <= x_sub_nxt;
            y_sub            <= y_sub_nxt;
            gx_cnt           <= gx_nxt;
            gy_cnt           <= gy_nxt;
            screen_en        <= screen_en_nxt;
            started          <= 1'b1;
            hsync_out        <= (h_state_nxt != SYNC);
            vsync_out        <= (v_state_nxt != SYNC);
            visible_out      <= vis_nxt;
            grid_valid_out   <= gv_nxt;
            grid_x_out       <= gv_nxt ? gx_nxt[6:0] : '0;
            grid_y_out       <= gv_nxt ? gy_nxt[5:0] : '0;
            en_load_out      <= el_nxt;
            line_start_out   <= (h_nxt == '0);
            frame_commit_out <= (h_nxt == '0) && (v_nxt == V_FRONT);
        end
    end

endmodule
